// File: rtl/shift_deser.sv
// shift_deser: serial-to-parallel receiver for framed words
// (start bit, W data bits, even parity, stop bit) with a one-word
// holding buffer on the parallel side.
//
// Handshake: dout/dvalid follow valid/ready rules. A word transfers on a
// rising edge where dvalid=1 and dready=1. While dvalid=1 and dready=0,
// dout is held stable and dvalid stays high. dvalid never depends
// combinationally on dready.
module shift_deser #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sin,
    input  logic         sen,
    input  logic         lsb_first,
    output logic [W-1:0] dout,
    output logic         dvalid,
    input  logic         dready,
    output logic         perr,
    output logic         ferr,
    output logic         ovf,
    input  logic         ovf_clr,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [W-1:0]   sh, sh_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           acc, acc_n;
    logic           lsb_q, lsb_n;
    logic           stop_seen;

    logic           stop_bad;
    logic           par_bad;
    logic           good;
    logic           xfer;
    logic           load;
    logic           drop;

    // Frame state register and bit collection datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
            acc   <= 1'b0;
            lsb_q <= 1'b0;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            cnt   <= cnt_n;
            acc   <= acc_n;
            lsb_q <= lsb_n;
        end
    end

    // Next-state logic: advance only on a strobe, otherwise hold everything
    always_comb begin
        state_n   = state;
        sh_n      = sh;
        cnt_n     = cnt;
        acc_n     = acc;
        lsb_n     = lsb_q;
        stop_seen = 1'b0;
        if (sen) begin
            case (state)
                IDLE: begin
                    // A high bit while idle is line idle, not a start bit
                    if (!sin) begin
                        lsb_n   = lsb_first;
                        cnt_n   = '0;
                        acc_n   = 1'b0;
                        state_n = DATA;
                    end
                end
                DATA: begin
                    sh_n  = lsb_q ? {sin, sh[W-1:1]} : {sh[W-2:0], sin};
                    acc_n = acc ^ sin;
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        state_n = PAR;
                    end
                end
                PAR: begin
                    acc_n   = acc ^ sin;
                    state_n = STOP;
                end
                STOP: begin
                    stop_seen = 1'b1;
                    state_n   = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Frame verdict on the stop strobe; sin is the stop bit at that point
    assign stop_bad = stop_seen & ~sin;
    assign par_bad  = stop_seen & acc;
    assign good     = stop_seen & sin & ~acc;
    assign xfer     = dvalid & dready;
    assign load     = good & (~dvalid | dready);
    assign drop     = good & dvalid & ~dready;

    // Holding buffer, error pulses and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout   <= '0;
            dvalid <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            perr <= par_bad;
            ferr <= stop_bad;
            if (load) begin
                dout   <= sh;
                dvalid <= 1'b1;
            end else if (xfer) begin
                dvalid <= 1'b0;
            end
            // A new drop outranks a clear on the same edge
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: doc/shift_deser.md
# shift_deser

Serial-to-parallel receiver, the receiving end of the team's shift-register datapath. It collects a framed serial bit stream: start bit, W data bits, even parity, stop bit. Bits arrive on a per-bit strobe in either MSB-first or LSB-first order. Checked words go out on a parallel port with a valid/ready handshake and a one-word holding buffer. Parity, framing and overflow errors are flagged to the surrounding control logic.

## Interface
- W, default 4: data word width in bits (W >= 2)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sin  in  1  serial data bit
- sen  in  1  bit strobe; sin is sampled on a rising edge only when sen=1
- lsb_first  in  1  bit order: 0 = MSB first, 1 = LSB first; captured with the start bit and held for the whole frame
- dout  out  W  received word (holding register)
- dvalid  out  1  dout holds an unconsumed word
- dready  in  1  downstream accepts dout
- perr  out  1  one-cycle pulse: parity error, word discarded
- ferr  out  1  one-cycle pulse: stop bit was 0, word discarded
- ovf  out  1  sticky: a good word was dropped because the buffer was full
- ovf_clr  in  1  clears ovf
- busy  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: a strobe with sin=0 is a start bit. Capture lsb_first, clear the bit counter and parity accumulator, go to DATA. A strobe with sin=1 is ignored.
  - DATA: each strobe shifts sin into the shift register and increments the counter. The strobe that makes the counter reach W goes to PAR.
    - MSB first: sh <= {sh[W-2:0], sin}.
    - LSB first: sh <= {sin, sh[W-1:1]}.
  - PAR: the strobe XORs sin into the accumulator and goes to STOP.
  - STOP: the strobe evaluates the frame and returns to IDLE.
- Cycles without sen hold all state. Gaps between strobes are unlimited.
- Parity: even. The XOR of the W data bits and the parity bit must be 0.
- Frame evaluation on the STOP strobe:
  - Stop bit 0: ferr pulses.
  - Parity bad: perr pulses.
  - Both faults: both pulse. Any faulty frame is discarded and dout/dvalid are unchanged.
  - Good frame, buffer empty or being emptied this edge: sh is loaded into dout and dvalid=1.
  - Good frame, buffer full (dvalid=1, dready=0): the word is dropped, dout is kept, ovf is set.
- Handshake: a word transfers on an edge with dvalid=1 and dready=1. dout is stable while dvalid=1 and dready=0.
- Simultaneous transfer and new good word: the new word loads and dvalid stays 1.
- ovf_clr on the same edge as an ovf set: set wins.
- Counter width is clog2(W+1). The counter never wraps mid-frame.

## Timing
- Reset values: dout=0, dvalid=0, perr=0, ferr=0, ovf=0, busy=0, state IDLE, sh=0, counter=0. Reset mid-frame abandons the frame with no error pulse.
- busy rises the cycle after the start strobe and falls the cycle after the stop strobe.
- Latency: dvalid, perr and ferr assert in the cycle following the edge that sampled the stop bit. The perr/ferr pulses last exactly 1 cycle.
- dvalid falls the cycle after a transfer edge, unless a new word loads on that edge.
- Minimum frame: W+3 consecutive strobed cycles. Back-to-back frames are allowed: a start bit may be strobed on the cycle right after the stop strobe.

## Test plan
All cases use W=4.
- MSB-first, dready=1: strobes 0,1,0,1,1,1,1 (start, data 1011, parity 1, stop) -> dout=1011, dvalid high for 1 cycle, no error flags.
- LSB-first, with idle gaps of 0-3 cycles between strobes: strobes 0,1,1,0,1,1,1 -> dout=1011. Also: a strobe with sin=1 in IDLE, and lsb_first toggled mid-frame -> both have no effect.
- Parity error: data 0111 (MSB first), parity 0, stop 1 -> perr pulses 1 cycle, dvalid stays 0, dout unchanged. Stop 0 with good parity -> only ferr pulses. Bad parity and stop 0 -> both pulse.
- Overflow, dready=0: frame 0011 then frame 1000 -> dout=0011, dvalid=1, ovf=1. Then dready=1 for 1 cycle -> dvalid=0. Then ovf_clr -> ovf=0.
- Simultaneous events:
  - Stop strobe of frame 1100 on the same edge as a dready transfer of 0011 -> dout=1100, dvalid stays 1.
  - ovf_clr on the same edge as a new overflow -> ovf stays 1.
- Reset mid-frame: assert rst_n=0 asynchronously after 2 data bits -> all outputs 0 immediately. After release, a full frame 1110 (parity 1) -> dout=1110 with no error pulses.
